// File: rtl/fx_arb2.sv
// fx_arb2: round-robin arbiter sharing one fx bus between two masters.
// One transaction in flight; write strobes one cycle after grant, reads wait
// RD_LAT cycles for fx_q before acking the owner.
module fx_arb2 #(
  parameter int AW     = 22,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] LAT = 4'(RD_LAT);

  state_t        state;
  logic          gnt;       // owner of the transaction in flight (0 = m0)
  logic          last_gnt;  // owner of the last completed transaction
  logic          cmd_we;
  logic [3:0]    cnt;

  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Pick the winner: a lone requester wins, a tie goes to the master not served last.
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) win = ~last_gnt;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
  end

  // Arbiter FSM. Strobe registers load on the IDLE->ISSUE edge so they are
  // high exactly during ISSUE; address/data go straight into the fx output
  // registers, which double as the latched command and hold between strobes.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      cmd_we   <= 1'b0;
      cnt      <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      fx_waddr <= '0;
      fx_data  <= '0;
      fx_raddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt    <= win;
            cmd_we <= sel_we;
            if (sel_we) begin
              fx_wr    <= 1'b1;
              fx_waddr <= sel_addr;
              fx_data  <= sel_wdata;
            end else begin
              fx_rd    <= 1'b1;
              fx_raddr <= sel_addr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          fx_wr <= 1'b0;
          fx_rd <= 1'b0;
          if (cmd_we) begin
            m0_ack <= ~gnt;
            m1_ack <= gnt;
            state  <= ACK;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // Last wait cycle is the one where fx_q is valid.
          if (cnt == 4'd1) begin
            if (gnt) m1_rdata <= fx_q;
            else     m0_rdata <= fx_q;
            m0_ack <= ~gnt;
            m1_ack <= gnt;
            state  <= ACK;
          end
        end
        ACK: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          last_gnt <= gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fx_arb2.sv
// tb_fx_arb2: directed + randomized bench for fx_arb2 with a schedule-based
// reference model; extra RD_LAT=1 / RD_LAT=15 instances for latency corners.
module tb_fx_arb2;
  localparam int AW  = 22;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          req[2], we[2], ack[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2], rdata[2];
  logic          fx_wr, fx_rd;
  logic [AW-1:0] fx_waddr, fx_raddr;
  logic [DW-1:0] fx_data, fx_q;

  int checks = 0;
  int errors = 0;

  fx_arb2 #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack[1]), .m1_rdata(rdata[1]),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q));

  // Latency-corner instances: index 0 is RD_LAT=1, index 1 is RD_LAT=15.
  logic          x_req[2], x_ack0[2], x_ack1[2], x_wr[2], x_rd[2];
  logic [AW-1:0] x_addr, x_waddr[2], x_raddr[2];
  logic [DW-1:0] x_rd0[2], x_rd1[2], x_data[2], x_q[2];
  logic          zero1 = 1'b0;
  logic [AW-1:0] zero_a = '0;
  logic [DW-1:0] zero_d = '0;

  fx_arb2 #(.AW(AW), .DW(DW), .RD_LAT(1)) u_l1 (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .m0_req(x_req[0]), .m0_we(zero1), .m0_addr(x_addr), .m0_wdata(zero_d),
    .m0_ack(x_ack0[0]), .m0_rdata(x_rd0[0]),
    .m1_req(zero1), .m1_we(zero1), .m1_addr(zero_a), .m1_wdata(zero_d),
    .m1_ack(x_ack1[0]), .m1_rdata(x_rd1[0]),
    .fx_wr(x_wr[0]), .fx_waddr(x_waddr[0]), .fx_data(x_data[0]),
    .fx_rd(x_rd[0]), .fx_raddr(x_raddr[0]), .fx_q(x_q[0]));

  fx_arb2 #(.AW(AW), .DW(DW), .RD_LAT(15)) u_l15 (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .m0_req(x_req[1]), .m0_we(zero1), .m0_addr(x_addr), .m0_wdata(zero_d),
    .m0_ack(x_ack0[1]), .m0_rdata(x_rd0[1]),
    .m1_req(zero1), .m1_we(zero1), .m1_addr(zero_a), .m1_wdata(zero_d),
    .m1_ack(x_ack1[1]), .m1_rdata(x_rd1[1]),
    .fx_wr(x_wr[1]), .fx_waddr(x_waddr[1]), .fx_data(x_data[1]),
    .fx_rd(x_rd[1]), .fx_raddr(x_raddr[1]), .fx_q(x_q[1]));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave read data as a pure function of address.
  function automatic logic [DW-1:0] sdata(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h63;
  endfunction

  // Slave: fx_q carries sdata(addr) exactly LAT cycles after the fx_rd cycle, noise otherwise.
  logic          h_v[16];
  logic [DW-1:0] h_d[16];
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) h_v[k] = 1'b0;
    end else begin
      for (int k = 15; k > 0; k--) begin
        h_v[k] = h_v[k-1];
        h_d[k] = h_d[k-1];
      end
      h_v[0] = fx_rd;
      h_d[0] = sdata(fx_raddr);
    end
    fx_q = h_v[LAT] ? h_d[LAT] : 8'($urandom);
  end

  // Reference model: on a grant at cycle c, schedule strobe at c+1, sample at
  // c+1+LAT, ack at c+2 (write) or c+2+LAT (read); nothing accepted while busy.
  logic          busy, m_gnt, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  int            cyc, t_iss, t_smp, t_ack;
  logic          e_wr, e_rd, e_ack[2];
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_data, e_rdata[2];

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0; m_last = 1'b1; cyc = 0;
      e_wr = 1'b0; e_rd = 1'b0; e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      e_waddr = '0; e_raddr = '0; e_data = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    end else begin
      if (busy) begin
        if (!m_we && cyc == t_smp) e_rdata[m_gnt] = sdata(m_addr);
        if (cyc == t_ack) begin
          busy   = 1'b0;
          m_last = m_gnt;
        end
      end else if (req[0] || req[1]) begin
        m_gnt  = (req[0] && req[1]) ? !m_last : req[1];
        m_we   = we[m_gnt];
        m_addr = addr[m_gnt];
        m_wd   = wdata[m_gnt];
        busy   = 1'b1;
        t_iss  = cyc + 1;
        t_smp  = cyc + 1 + LAT;
        t_ack  = m_we ? cyc + 2 : cyc + 2 + LAT;
      end
      cyc++;
      e_wr = busy && m_we && cyc == t_iss;
      e_rd = busy && !m_we && cyc == t_iss;
      if (e_wr) begin
        e_waddr = m_addr;
        e_data  = m_wd;
      end
      if (e_rd) e_raddr = m_addr;
      e_ack[0] = busy && cyc == t_ack && !m_gnt;
      e_ack[1] = busy && cyc == t_ack && m_gnt;
    end
  end

  // Cycle-by-cycle comparison of every main-DUT output against the model.
  always @(negedge clk_sys) begin
    chk("m_fx_wr", fx_wr, e_wr);
    chk("m_fx_rd", fx_rd, e_rd);
    chk("m_fx_waddr", fx_waddr, e_waddr);
    chk("m_fx_data", fx_data, e_data);
    chk("m_fx_raddr", fx_raddr, e_raddr);
    chk("m_ack0", ack[0], e_ack[0]);
    chk("m_ack1", ack[1], e_ack[1]);
    chk("m_rdata0", rdata[0], e_rdata[0]);
    chk("m_rdata1", rdata[1], e_rdata[1]);
  end

  initial begin
    int n, last;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      x_req[i] = 1'b0; x_q[i] = '0;
    end
    x_addr = '0;

    repeat (3) @(negedge clk_sys);
    chk("rst_fx_wr", fx_wr, 0);
    chk("rst_ack0", ack[0], 0);
    chk("rst_rdata1", rdata[1], 0);
    #1 rst_n = 1'b1;
    @(negedge clk_sys);

    // m0 write alone
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 22'h000123; wdata[0] = 8'hA5;
    @(negedge clk_sys);
    chk("t1_wr", fx_wr, 1);
    chk("t1_waddr", fx_waddr, 22'h000123);
    chk("t1_data", fx_data, 8'hA5);
    chk("t1_ack_early", ack[0], 0);
    @(negedge clk_sys);
    chk("t1_ack", ack[0], 1);
    chk("t1_m1_ack", ack[1], 0);
    chk("t1_wr_off", fx_wr, 0);
    req[0] = 1'b0;
    @(negedge clk_sys);
    chk("t1_ack_once", ack[0], 0);

    // m1 read of the top address
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 22'h3FFFFF;
    @(negedge clk_sys);
    chk("t2_rd", fx_rd, 1);
    chk("t2_raddr", fx_raddr, 22'h3FFFFF);
    repeat (2) @(negedge clk_sys);
    chk("t2_ack_early", ack[1], 0);
    @(negedge clk_sys);
    chk("t2_ack", ack[1], 1);
    chk("t2_rdata", rdata[1], 8'h5C);
    chk("t2_m0_rdata", rdata[0], 0);
    req[1] = 1'b0;
    @(negedge clk_sys);

    // both masters writing continuously: alternate, one write per 3 cycles
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 22'h000010; wdata[0] = 8'h11;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 22'h000020; wdata[1] = 8'h22;
    n = 0; last = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk_sys);
      if (fx_wr) begin
        chk("t3_owner", fx_waddr, (n % 2 == 0) ? 22'h000010 : 22'h000020);
        if (n > 0) chk("t3_gap", i - last, 3);
        last = i;
        n++;
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    chk("t3_count", n, 6);
    @(negedge clk_sys);

    // m0 drops req right after its grant
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 22'h0ABCDE; wdata[0] = 8'h3C;
    @(negedge clk_sys);
    req[0] = 1'b0;
    chk("t4_wr", fx_wr, 1);
    chk("t4_waddr", fx_waddr, 22'h0ABCDE);
    @(negedge clk_sys);
    chk("t4_ack", ack[0], 1);
    @(negedge clk_sys);
    chk("t4_ack_once", ack[0], 0);

    // reset during the WAIT of an m0 read
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 22'h001234;
    @(negedge clk_sys);
    chk("t5_rd", fx_rd, 1);
    @(negedge clk_sys);
    @(posedge clk_sys);
    #1 rst_n = 1'b0;
    req[0] = 1'b0;
    @(negedge clk_sys);
    chk("t5_rst_waddr", fx_waddr, 0);
    chk("t5_rst_raddr", fx_raddr, 0);
    chk("t5_rst_ack0", ack[0], 0);
    chk("t5_rst_rdata0", rdata[0], 0);
    #1 rst_n = 1'b1;
    @(negedge clk_sys);
    chk("t5_no_ack", ack[0], 0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 22'h000055; wdata[0] = 8'h5A;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 22'h000066; wdata[1] = 8'h6B;
    @(negedge clk_sys);
    chk("t5_tie_m0", fx_waddr, 22'h000055);
    @(negedge clk_sys);
    chk("t5_ack0", ack[0], 1);
    req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk_sys);

    // RD_LAT=1 and RD_LAT=15 single reads
    x_addr = 22'h02A5A5; x_req[0] = 1'b1; x_req[1] = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk_sys);
      x_q[0] = (i == 2)  ? 8'h96 : 8'h69;
      x_q[1] = (i == 16) ? 8'hC3 : 8'h3C;
      if (i == 1) begin
        chk("l1_rd", x_rd[0], 1);
        chk("l15_rd", x_rd[1], 1);
        chk("l15_raddr", x_raddr[1], 22'h02A5A5);
      end
      chk("l1_ack", x_ack0[0], i == 3);
      chk("l15_ack", x_ack0[1], i == 17);
      if (i == 3) begin
        chk("l1_rdata", x_rd0[0], 8'h96);
        x_req[0] = 1'b0;
      end
      if (i == 17) begin
        chk("l15_rdata", x_rd0[1], 8'hC3);
        x_req[1] = 1'b0;
      end
    end

    // randomized traffic with occasional drops and resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_sys);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(15) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) begin
          req[i]   = 1'b1;
          we[i]    = 1'($urandom_range(1));
          wdata[i] = 8'($urandom);
          case ($urandom_range(3))
            0:       addr[i] = '0;
            1:       addr[i] = 22'h3FFFFF;
            default: addr[i] = AW'($urandom);
          endcase
        end
      end
      if ($urandom_range(399) == 0) begin
        @(posedge clk_sys);
        #1 rst_n = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0;
        @(negedge clk_sys);
        #1 rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
